time_set_ctrl: RTL and testbench

- Button-driven setting sequencer for the digital clock.
- Debounces three raw push-buttons and steps an edit FSM through hour/min/sec of the time and hour/min of the alarm.
- Edits a shadow copy of the time, then presents it to the timekeeping block with a one-cycle set_time_finish strobe.
- Owns the alarm time register and the alarm-enable flag, which feed the timekeeping block's alarm inputs.

---
 rtl/time_set_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button debouncing and time/alarm edit sequencer for the digital clock
// Optional feature macro: BTN_REPEAT_EN (auto-repeat of a held increment button)
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned TIMEOUT_CYCLES  = 50000000,
    parameter int unsigned REPEAT_DELAY    = 10000000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_ok,
    input  logic [23:0] cur_time,
    output logic [23:0] set_time,
    output logic        set_time_finish,
    output logic [15:0] alarm_time,
    output logic        clock_en,
    output logic [2:0]  edit_field
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES == 0 ||
        REPEAT_PERIOD == 0 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
        $error("time_set_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_T_HOUR, S_T_MIN, S_T_SEC, S_COMMIT, S_A_HOUR, S_A_MIN
    } state_t;

    // Button index: 2 = ok, 1 = mode, 0 = inc
    logic [2:0]     raw;
    logic [2:0]     sync1_q, sync2_q, acc_q, press_q;
    logic [DBW-1:0] db_cnt_q [3];

    assign raw = {btn_ok, btn_mode, btn_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == acc_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    acc_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                    press_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic inc_pulse;

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_cnt_q;
    logic          rep_armed_q, rep_pulse_q, inc_held;

    // Raw release (synchronized level low) stops repeats without waiting for debounce.
    assign inc_held = acc_q[0] & sync2_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_pulse_q <= 1'b0;
        end else begin
            rep_pulse_q <= 1'b0;
            if (!inc_held) begin
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b0;
            end else if (!rep_armed_q && rep_cnt_q == RW'(REPEAT_DELAY - 1)) begin
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b1;
                rep_pulse_q <= 1'b1;
            end else if (rep_armed_q && rep_cnt_q == RW'(REPEAT_PERIOD - 1)) begin
                rep_cnt_q   <= '0;
                rep_pulse_q <= 1'b1;
            end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
            end
        end
    end

    assign inc_pulse = press_q[0] | rep_pulse_q;
`else
    assign inc_pulse = press_q[0];
`endif

    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)           r = 8'h00;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9)  r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else                 r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [23:0]    shadow_q, shadow_d, set_time_q, set_time_d;
    logic [15:0]    alarm_q, alarm_d;
    logic           clock_en_q, clock_en_d, to_alarm_q, to_alarm_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic           ok_p, mode_p, inc_p, any_p, in_edit;

    assign ok_p    = press_q[2];
    assign mode_p  = press_q[1] & ~press_q[2];
    assign inc_p   = inc_pulse & ~press_q[2] & ~press_q[1];
    assign any_p   = press_q[2] | press_q[1] | inc_pulse;
    assign in_edit = (state_q != S_IDLE) && (state_q != S_COMMIT);

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        set_time_d = set_time_q;
        alarm_d    = alarm_q;
        clock_en_d = clock_en_q;
        to_alarm_d = to_alarm_q;
        tmo_d      = (in_edit && !any_p) ? tmo_q + 1'b1 : '0;

        case (state_q)
            S_IDLE: begin
                if (ok_p) begin
                    clock_en_d = ~clock_en_q;
                end else if (mode_p) begin
                    shadow_d = cur_time;
                    state_d  = S_T_HOUR;
                end
            end
            S_T_HOUR, S_T_MIN, S_T_SEC: begin
                if (ok_p || (mode_p && state_q == S_T_SEC)) begin
                    // set_time loads on entry so it is already stable during the strobe
                    to_alarm_d = mode_p;
                    set_time_d = shadow_q;
                    state_d    = S_COMMIT;
                end else if (mode_p) begin
                    state_d = (state_q == S_T_HOUR) ? S_T_MIN : S_T_SEC;
                end else if (inc_p) begin
                    case (state_q)
                        S_T_HOUR: shadow_d[23:16] = bcd_inc_hour(shadow_q[23:16]);
                        S_T_MIN:  shadow_d[15:8]  = bcd_inc_60(shadow_q[15:8]);
                        default:  shadow_d[7:0]   = bcd_inc_60(shadow_q[7:0]);
                    endcase
                end
            end
            S_COMMIT: begin
                state_d = to_alarm_q ? S_A_HOUR : S_IDLE;
            end
            S_A_HOUR: begin
                if (ok_p)        state_d = S_IDLE;
                else if (mode_p) state_d = S_A_MIN;
                else if (inc_p)  alarm_d[15:8] = bcd_inc_hour(alarm_q[15:8]);
            end
            S_A_MIN: begin
                if (ok_p || mode_p) state_d = S_IDLE;
                else if (inc_p)     alarm_d[7:0] = bcd_inc_60(alarm_q[7:0]);
            end
            default: state_d = S_IDLE;
        endcase

        if (in_edit && !any_p && tmo_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            set_time_q <= '0;
            alarm_q    <= '0;
            clock_en_q <= 1'b0;
            to_alarm_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            set_time_q <= set_time_d;
            alarm_q    <= alarm_d;
            clock_en_q <= clock_en_d;
            to_alarm_q <= to_alarm_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        edit_field = 3'd0;
        case (state_q)
            S_T_HOUR: edit_field = 3'd1;
            S_T_MIN:  edit_field = 3'd2;
            S_T_SEC:  edit_field = 3'd3;
            S_A_HOUR: edit_field = 3'd4;
            S_A_MIN:  edit_field = 3'd5;
            default:  edit_field = 3'd0;
        endcase
    end

    assign set_time        = set_time_q;
    assign set_time_finish = (state_q == S_COMMIT);
    assign alarm_time      = alarm_q;
    assign clock_en        = clock_en_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed vector bench for time_set_ctrl
module tb_time_set_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 200;
    localparam int RDL = 40;
    localparam int RPR = 10;
    localparam int HOLD = 100;

    localparam logic [2:0] B_INC  = 3'b001;
    localparam logic [2:0] B_MODE = 3'b010;
    localparam logic [2:0] B_OK   = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0;
    logic [23:0] cur_time = '0;
    logic [23:0] set_time;
    logic        set_time_finish;
    logic [15:0] alarm_time;
    logic        clock_en;
    logic [2:0]  edit_field;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .REPEAT_DELAY   (RDL),
        .REPEAT_PERIOD  (RPR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_mode       (btn_mode),
        .btn_inc        (btn_inc),
        .btn_ok         (btn_ok),
        .cur_time       (cur_time),
        .set_time       (set_time),
        .set_time_finish(set_time_finish),
        .alarm_time     (alarm_time),
        .clock_en       (clock_en),
        .edit_field     (edit_field)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  btn;
        logic [23:0] cur;
        logic [23:0] exp_set;
        logic [15:0] exp_alarm;
        logic        exp_ce;
        logic [2:0]  exp_ef;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0, n_err = 0;
    int   strobes = 0, wide = 0, strobe_base = 0, wide_base = 0;
    logic fin_prev = 1'b0;

    always @(negedge clk) begin
        if (set_time_finish) begin
            strobes++;
            if (fin_prev) wide++;
        end
        fin_prev = set_time_finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [2:0] b, input logic [23:0] c, input logic [23:0] es,
                                input logic [15:0] ea, input logic ce, input logic [2:0] ef, input int s);
        vec_t v;
        v.btn = b; v.cur = c; v.exp_set = es; v.exp_alarm = ea;
        v.exp_ce = ce; v.exp_ef = ef; v.exp_strobes = s;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [23:0] es, input logic [15:0] ea,
                         input logic ce, input logic [2:0] ef, input int s);
        int ds, dw;
        ds = strobes - strobe_base;
        dw = wide - wide_base;
        n_vec++;
        if (set_time !== es || alarm_time !== ea || clock_en !== ce || edit_field !== ef ||
            ds != s || dw != 0) begin
            n_err++;
            $display("FAIL %s: got set_time=%h alarm=%h clock_en=%b edit_field=%0d strobes=%0d wide=%0d, want set_time=%h alarm=%h clock_en=%b edit_field=%0d strobes=%0d wide=0",
                     name, set_time, alarm_time, clock_en, edit_field, ds, dw, es, ea, ce, ef, s);
        end
        strobe_base = strobes;
        wide_base   = wide;
    endtask

    task automatic press(input logic [2:0] b);
        {btn_ok, btn_mode, btn_inc} = b;
        repeat (8) @(negedge clk);
        {btn_ok, btn_mode, btn_inc} = 3'b000;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int held, reps, secs;
        logic [23:0] exp_rep;

        // 23:59:58 -> hour rolls 23->00, commit straight back to IDLE
        add(B_MODE, 24'h235958, 24'h000000, 16'h0000, 1'b0, 3'd1, 0);
        add(B_INC,  24'h235958, 24'h000000, 16'h0000, 1'b0, 3'd1, 0);
        add(B_OK,   24'h235958, 24'h005958, 16'h0000, 1'b0, 3'd0, 1);
        // 12:34:56 full walk through time fields into alarm edit
        add(B_MODE, 24'h123456, 24'h005958, 16'h0000, 1'b0, 3'd1, 0);
        add(B_MODE, 24'h123456, 24'h005958, 16'h0000, 1'b0, 3'd2, 0);
        for (int i = 0; i < 7; i++) add(B_INC, 24'h123456, 24'h005958, 16'h0000, 1'b0, 3'd2, 0);
        add(B_MODE, 24'h123456, 24'h005958, 16'h0000, 1'b0, 3'd3, 0);
        for (int i = 0; i < 4; i++) add(B_INC, 24'h123456, 24'h005958, 16'h0000, 1'b0, 3'd3, 0);
        add(B_MODE, 24'h123456, 24'h124100, 16'h0000, 1'b0, 3'd4, 1);
        add(B_INC,  24'h123456, 24'h124100, 16'h0100, 1'b0, 3'd4, 0);
        add(B_INC,  24'h123456, 24'h124100, 16'h0200, 1'b0, 3'd4, 0);
        add(B_INC,  24'h123456, 24'h124100, 16'h0300, 1'b0, 3'd4, 0);
        add(B_MODE, 24'h123456, 24'h124100, 16'h0300, 1'b0, 3'd5, 0);
        add(B_INC,  24'h123456, 24'h124100, 16'h0301, 1'b0, 3'd5, 0);
        add(B_OK,   24'h123456, 24'h124100, 16'h0301, 1'b0, 3'd0, 0);
        // clock_en toggling, ok wins over a coincident mode
        add(B_OK,          24'h123456, 24'h124100, 16'h0301, 1'b1, 3'd0, 0);
        add(B_OK,          24'h123456, 24'h124100, 16'h0301, 1'b0, 3'd0, 0);
        add(B_OK | B_MODE, 24'h123456, 24'h124100, 16'h0301, 1'b1, 3'd0, 0);
        // hour tens carries 08->09->10 and 19->20
        add(B_MODE, 24'h085900, 24'h124100, 16'h0301, 1'b1, 3'd1, 0);
        add(B_INC,  24'h085900, 24'h124100, 16'h0301, 1'b1, 3'd1, 0);
        add(B_INC,  24'h085900, 24'h124100, 16'h0301, 1'b1, 3'd1, 0);
        add(B_OK,   24'h085900, 24'h105900, 16'h0301, 1'b1, 3'd0, 1);
        add(B_MODE, 24'h195959, 24'h105900, 16'h0301, 1'b1, 3'd1, 0);
        add(B_INC,  24'h195959, 24'h105900, 16'h0301, 1'b1, 3'd1, 0);
        add(B_OK,   24'h195959, 24'h205959, 16'h0301, 1'b1, 3'd0, 1);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("reset", 24'h0, 16'h0, 1'b0, 3'd0, 0);

        btn_inc = 1'b1;
        repeat (2) @(negedge clk);
        btn_inc = 1'b0;
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        repeat (16) @(negedge clk);
        check("glitch", 24'h0, 16'h0, 1'b0, 3'd0, 0);

        foreach (vecs[i]) begin
            cur_time = vecs[i].cur;
            press(vecs[i].btn);
            check($sformatf("vec%0d", i), vecs[i].exp_set, vecs[i].exp_alarm,
                  vecs[i].exp_ce, vecs[i].exp_ef, vecs[i].exp_strobes);
        end

        cur_time = 24'h101010;
        press(B_MODE);
        press(B_MODE);
        press(B_INC);
        press(B_INC);
        check("tmo_enter", 24'h205959, 16'h0301, 1'b1, 3'd2, 0);
        repeat (150) @(negedge clk);
        check("tmo_early", 24'h205959, 16'h0301, 1'b1, 3'd2, 0);
        repeat (60) @(negedge clk);
        check("tmo_abort", 24'h205959, 16'h0301, 1'b1, 3'd0, 0);

        cur_time = 24'h010203;
        press(B_MODE);
        press(B_MODE);
        press(B_MODE);
        check("rst_pre", 24'h205959, 16'h0301, 1'b1, 3'd3, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid", 24'h0, 16'h0, 1'b0, 3'd0, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        cur_time = 24'h000000;
        press(B_MODE);
        press(B_MODE);
        press(B_MODE);
        btn_inc = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_inc = 1'b0;
        repeat (16) @(negedge clk);
        check("hold_ef", 24'h0, 16'h0, 1'b0, 3'd3, 0);
        press(B_OK);
`ifdef BTN_REPEAT_EN
        // Synchronized level stays high for HOLD-4 edges past debounce acceptance
        held = HOLD - 4;
        reps = (held >= RDL) ? 1 + (held - RDL) / RPR : 0;
`else
        held = 0;
        reps = held;
`endif
        secs = 1 + reps;
        exp_rep = {16'h0000, 4'(secs / 10), 4'(secs % 10)};
        check("hold_inc", exp_rep, 16'h0, 1'b0, 3'd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
